// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with optional single-cycle completion for trivial operands.
module muldiv_iter #(
    parameter int unsigned XLEN      = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_is_div;
    logic              r_hi;
    logic              r_rem;
    logic              r_neg;
    logic [XLEN-1:0]   r_opnd;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_result;
    logic              r_busy;
    logic              r_done;

    logic              w_sa;
    logic              w_sb;
    logic              w_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_div_rem;
    logic [XLEN:0]     w_div_diff;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_div_sel;
    logic [XLEN-1:0]   w_final;

    // Operand decode at the start edge: MULH/MULHSU/DIV/REM sign a; MULH/DIV/REM sign b
    always_comb begin
        w_sa    = op_a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                  (funct3 == 3'b100) | (funct3 == 3'b110));
        w_sb    = op_b[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110));
        w_mag_a = w_sa ? ('0 - op_a) : op_a;
        w_mag_b = w_sb ? ('0 - op_b) : op_b;
        w_neg   = w_sa ^ w_sb;
        if (funct3[2]) begin
            w_neg = funct3[1] ? w_sa : ((w_sa ^ w_sb) & (op_b != '0));
        end
    end

    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (funct3[2]) begin
            if (op_b == '0) begin
                w_special     = 1'b1;
                w_special_res = funct3[1] ? op_a : '1;
            end else if (!funct3[0] && (op_a == SMIN) && (op_b == '1)) begin
                w_special     = 1'b1;
                w_special_res = funct3[1] ? '0 : op_a;
            end
        end else if ((op_a == '0) || (op_b == '0)) begin
            w_special = 1'b1;
        end
    end

    // Multiply: multiplier sits in the low half of r_acc and shifts out as the product shifts in.
    // Divide: r_acc = {remainder, dividend/quotient}, quotient bits enter at the bottom.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        w_div_rem  = r_acc[2*XLEN-1:XLEN-1];
        w_div_diff = w_div_rem - {1'b0, r_opnd};
        w_div_next = w_div_diff[XLEN] ? {w_div_rem[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                      : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        w_acc_next = r_is_div ? w_div_next : w_mul_next;
        w_prod     = r_neg ? ('0 - w_acc_next) : w_acc_next;
        w_div_sel  = r_rem ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
        if (r_is_div) begin
            w_final = r_neg ? ('0 - w_div_sel) : w_div_sel;
        end else begin
            w_final = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_hi     <= 1'b0;
            r_rem    <= 1'b0;
            r_neg    <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && !flush) begin
                        r_cnt    <= '0;
                        r_is_div <= funct3[2];
                        r_hi     <= (funct3[1:0] != 2'b00);
                        r_rem    <= funct3[1];
                        r_neg    <= w_neg;
                        if (EARLY_OUT && w_special) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_special_res;
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_acc   <= {{XLEN{1'b0}}, (funct3[2] ? w_mag_a : w_mag_b)};
                            r_opnd  <= funct3[2] ? w_mag_b : w_mag_a;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(XLEN-1)) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_result <= w_final;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter: one EARLY_OUT=1 and one EARLY_OUT=0 instance
// share stimulus and are compared each cycle against a timing/arithmetic model.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic [1:0]        busy_w;
    logic [1:0]        done_w;
    logic [1:0][31:0]  res_w;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b1)) dut_e (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0])
    );

    muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Architectural result of an M-extension op, straight from the ISA rules
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'h0, a};
        logic [63:0] ub = {32'h0, b};
        logic [63:0] p;
        longint      q;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb; return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (a == 0) || (b == 0);
    endfunction

    typedef struct {
        bit          busy;
        bit          done;
        bit          pend;
        int          due;
        logic [31:0] res;
        logic [31:0] pval;
    } mstate_t;

    mstate_t m[2];

    function automatic mstate_t mzero();
        mstate_t s;
        s.busy = 0; s.done = 0; s.pend = 0; s.due = 0; s.res = '0; s.pval = '0;
        return s;
    endfunction

    // One clock edge ending cycle c: an op accepted in cycle t is busy t+1..t+32, done at t+33
    function automatic mstate_t step(input mstate_t s, input bit early, input int c);
        mstate_t n = s;
        n.done = 0;
        if (s.busy) begin
            if (flush) n.pend = 0;
            else if (s.due == c + 1) begin n.done = 1; n.res = s.pval; n.pend = 0; end
        end else if (start && !flush) begin
            if (early && is_special(funct3, op_a, op_b)) begin
                n.done = 1; n.res = ref_op(funct3, op_a, op_b); n.pend = 0;
            end else begin
                n.pend = 1; n.due = c + 33; n.pval = ref_op(funct3, op_a, op_b);
            end
        end
        n.busy = n.pend;
        return n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m[0] <= mzero();
            m[1] <= mzero();
        end else begin
            m[0] <= step(m[0], 1'b1, cyc);
            m[1] <= step(m[1], 1'b0, cyc);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(m[k].busy));
            chk($sformatf("done%0d", k), 32'(done_w[k]), 32'(m[k].done));
            chk($sformatf("result%0d", k), res_w[k], m[k].res);
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input string nm);
        int          lat[2];
        logic [31:0] r[2];
        int          nb[2];
        bit          sp;
        sp = is_special(f, a, b);
        chk({nm, "_model"}, ref_op(f, a, b), lit);
        lat = '{0, 0};
        nb  = '{0, 0};
        @(posedge clk); #1;
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (busy_w[k]) nb[k]++;
                if (done_w[k] && lat[k] == 0) begin lat[k] = i; r[k] = res_w[k]; end
            end
        end
        chk({nm, "_lat_early"}, lat[0], sp ? 1 : 33);
        chk({nm, "_res_early"}, r[0], lit);
        chk({nm, "_busy_early"}, nb[0], sp ? 0 : 32);
        chk({nm, "_lat_norm"}, lat[1], 33);
        chk({nm, "_res_norm"}, r[1], lit);
        chk({nm, "_busy_norm"}, nb[1], 32);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_res", res_w[1], 32'h0);

        do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div");
        do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem");
        do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
        do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
        do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        do_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "rem_ovf");
        do_op(3'd0, 32'h0, 32'h1234_5678, 32'h0, "mul_zero");

        // Flush a DIV at cycle 10, then MUL 3x4 at cycle 12 completes at 45
        begin
            logic [31:0] prev[2];
            int          nd[2];
            int          at[2];
            prev = '{res_w[0], res_w[1]};
            nd = '{0, 0};
            at = '{0, 0};
            @(posedge clk); #1;
            start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
            for (int i = 1; i <= 50; i++) begin
                @(posedge clk); #1;
                start = (i == 12); flush = (i == 10);
                funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
                @(negedge clk);
                for (int k = 0; k < 2; k++) begin
                    if (done_w[k]) begin nd[k]++; at[k] = i; end
                    if (i == 44) chk($sformatf("flush_hold%0d", k), res_w[k], prev[k]);
                    if (i == 45) chk($sformatf("flush_mul%0d", k), res_w[k], 32'd12);
                end
            end
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("flush_ndone%0d", k), nd[k], 1);
                chk($sformatf("flush_at%0d", k), at[k], 45);
            end
        end

        // start held through done: accepted again in DONE, second pulse 33 cycles later
        begin
            int first;
            int second;
            first = 0; second = 0;
            @(posedge clk); #1;
            start = 1'b1; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
            for (int i = 1; i <= 75; i++) begin
                @(posedge clk); #1;
                start = (i <= 33);
                @(negedge clk);
                if (done_w[1]) begin
                    if (first == 0) first = i; else if (second == 0) second = i;
                end
            end
            chk("b2b_first", first, 33);
            chk("b2b_gap", second - first, 33);
        end

        // Async reset mid-CALC
        begin
            int nd;
            nd = 0;
            @(posedge clk); #1;
            start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5;
            for (int i = 1; i <= 5; i++) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            chk("pre_reset_busy", 32'(busy_w[1]), 32'h1);
            #2 reset_n = 1'b0;
            #1;
            chk("areset_busy", 32'(busy_w), 32'h0);
            chk("areset_done", 32'(done_w), 32'h0);
            chk("areset_res0", res_w[0], 32'h0);
            chk("areset_res1", res_w[1], 32'h0);
            repeat (2) @(posedge clk);
            #1 reset_n = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done_w != 2'b00) nd++;
            end
            chk("reset_no_done", nd, 0);
        end

        repeat (3000) begin
            @(posedge clk); #1;
            start  = ($urandom_range(0, 2) == 0);
            funct3 = 3'($urandom_range(0, 7));
            op_a   = pick();
            op_b   = pick();
            flush  = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_err);
        $fatal(1);
    end

endmodule
